// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit MEM-stage load/store into two 16-bit
// accesses (low half, then high half) on the board's asynchronous SRAM.
module sram_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  logic [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N
);

   localparam int CW = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LO   = 2'd1;
   localparam logic [1:0] HI   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          op;
   logic [16:0]   idx;
   logic [31:0]   wdata;
   logic [16:0]   req_idx;
   logic          last;
   logic          drive;

   // Out-of-range addresses simply wrap into the 17-bit word index.
   assign req_idx = 17'((address - 32'(BASE_ADDR)) >> 2);
   assign last    = (cnt == LAST_CNT);

   // SRAM_ADDR is registered on the edge entering each phase so it is
   // already stable in that phase's first cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= 1'b0;
         idx       <= '0;
         wdata     <= '0;
         read_data <= '0;
         SRAM_ADDR <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_en || wr_en) begin
                  op        <= wr_en;
                  idx       <= req_idx;
                  wdata     <= write_data;
                  cnt       <= '0;
                  SRAM_ADDR <= {req_idx, 1'b0};
                  state     <= LO;
               end
            end
            LO: begin
               if (last) begin
                  cnt       <= '0;
                  SRAM_ADDR <= {idx, 1'b1};
                  state     <= HI;
                  if (!op) read_data[15:0] <= SRAM_DQ;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HI: begin
               if (last) begin
                  cnt   <= '0;
                  state <= DONE;
                  if (!op) read_data[31:16] <= SRAM_DQ;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

   assign drive     = op && ((state == LO) || (state == HI));
   assign SRAM_WE_N = ~drive;
   assign SRAM_DQ   = drive ? ((state == LO) ? wdata[15:0] : wdata[31:16]) : 16'bz;

   // A fresh request in IDLE must stall immediately, before it is latched.
   assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a transaction-level model of the 32-bit word
// memory plus a 16-bit SRAM array attached to the DUT's pins.
module tb_sram_controller;

   localparam int W    = 2;
   localparam int BASE = 1024;
   localparam int MAXC = 24;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N;
   logic        SRAM_LB_N;
   logic        SRAM_CE_N;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;

   int compared;
   int mismatched;
   logic chk_en;
   logic sram_clear;

   logic [15:0] sram_mem [0:255];
   logic [31:0] model_mem [0:127];

   int          step;
   logic        m_op;
   logic [16:0] m_idx;
   logic [31:0] m_wd;
   logic [17:0] exp_addr;
   logic [31:0] exp_rd;

   logic [31:0] obs_addr [0:31];
   logic [31:0] obs_dq [0:31];
   logic [31:0] obs_we [0:31];
   logic [31:0] obs_ready [0:31];

   logic        e_lo;
   logic        e_hi;
   logic        e_we;
   logic        e_ready;
   logic [15:0] e_dq;
   int          lat;

   sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .address(address),
      .write_data(write_data),
      .read_data(read_data),
      .ready(ready),
      .SRAM_DQ(SRAM_DQ),
      .SRAM_ADDR(SRAM_ADDR),
      .SRAM_UB_N(SRAM_UB_N),
      .SRAM_LB_N(SRAM_LB_N),
      .SRAM_CE_N(SRAM_CE_N),
      .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // With CE_N/OE_N tied low the chip drives the bus whenever WE_N is high.
   assign SRAM_DQ = SRAM_WE_N ? sram_mem[SRAM_ADDR[7:0]] : 16'bz;

   always @(posedge clk) begin
      if (sram_clear) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
      end else if (!SRAM_WE_N) begin
         sram_mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] mem_half(input logic [7:0] a);
      logic [31:0] w;
      w = model_mem[a[7:1]];
      return a[0] ? w[31:16] : w[15:0];
   endfunction

   // Model: step counts cycles since the request (1..W low half, W+1..2W high
   // half, 2W+1 the ready cycle); -1 means idle.
   always @(posedge clk) begin
      if (sram_clear) begin
         for (int i = 0; i < 128; i++) model_mem[i] <= '0;
      end
      if (!rst) begin
         step     <= -1;
         m_op     <= 1'b0;
         exp_addr <= '0;
         exp_rd   <= '0;
      end else if (step < 0) begin
         if (rd_en || wr_en) begin
            step     <= 1;
            m_op     <= wr_en;
            m_idx    <= 17'((address - 32'(BASE)) >> 2);
            m_wd     <= write_data;
            exp_addr <= {17'((address - 32'(BASE)) >> 2), 1'b0};
         end
      end else if (step == 2 * W + 1) begin
         step <= -1;
      end else begin
         step <= step + 1;
         if (step == W) begin
            exp_addr <= {m_idx, 1'b1};
            if (!m_op) exp_rd[15:0] <= model_mem[m_idx[6:0]][15:0];
         end else if (step == 2 * W) begin
            if (m_op) model_mem[m_idx[6:0]] <= m_wd;
            else exp_rd[31:16] <= model_mem[m_idx[6:0]][31:16];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         e_lo    = (step >= 1) && (step <= W);
         e_hi    = (step > W) && (step <= 2 * W);
         e_we    = !(m_op && (e_lo || e_hi));
         e_ready = ((step < 0) && !rd_en && !wr_en) || (step == 2 * W + 1);
         e_dq    = e_we ? mem_half(exp_addr[7:0]) : (e_lo ? m_wd[15:0] : m_wd[31:16]);
         checkOutput("ready", 32'(ready), 32'(e_ready));
         checkOutput("sram_we_n", 32'(SRAM_WE_N), 32'(e_we));
         checkOutput("sram_addr", 32'(SRAM_ADDR), 32'(exp_addr));
         checkOutput("sram_dq", 32'(SRAM_DQ), 32'(e_dq));
         checkOutput("read_data", read_data, exp_rd);
         checkOutput("sram_ctl_n", 32'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 32'd0);
      end
   end

   // Issues one request and records pins per cycle until ready rises; leaves
   // the request asserted so a following call starts right after DONE.
   task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a,
                                input logic [31:0] d, output int latency);
      @(posedge clk);
      #1;
      wr_en = w;
      rd_en = r;
      address = a;
      write_data = d;
      latency = -1;
      for (int c = 0; c <= MAXC; c++) begin
         @(negedge clk);
         obs_addr[c]  = 32'(SRAM_ADDR);
         obs_dq[c]    = 32'(SRAM_DQ);
         obs_we[c]    = 32'(SRAM_WE_N);
         obs_ready[c] = 32'(ready);
         if (ready) begin
            latency = c;
            break;
         end
      end
      checkOutput("ready_seen", 32'(ready), 32'd1);
   endtask

   task automatic goIdle;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      chk_en = 1'b0;
      sram_clear = 1'b1;
      rst = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      address = '0;
      write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      sram_clear = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      checkOutput("rst_read_data", read_data, 32'd0);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      checkOutput("rst_addr", 32'(SRAM_ADDR), 32'd0);
      checkOutput("rst_dq_released", 32'(SRAM_DQ), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      $display("[TB] store 0xDEADBEEF to 1032");
      applyStimulus(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, lat);
      checkOutput("store_latency", 32'(lat), 32'd5);
      checkOutput("store_ready_c0", obs_ready[0], 32'd0);
      checkOutput("store_addr_c1", obs_addr[1], 32'd4);
      checkOutput("store_addr_c2", obs_addr[2], 32'd4);
      checkOutput("store_dq_c1", obs_dq[1], 32'h0000BEEF);
      checkOutput("store_dq_c2", obs_dq[2], 32'h0000BEEF);
      checkOutput("store_addr_c3", obs_addr[3], 32'd5);
      checkOutput("store_addr_c4", obs_addr[4], 32'd5);
      checkOutput("store_dq_c3", obs_dq[3], 32'h0000DEAD);
      checkOutput("store_dq_c4", obs_dq[4], 32'h0000DEAD);
      for (int c = 1; c <= 4; c++) checkOutput($sformatf("store_we_n_c%0d", c), obs_we[c], 32'd0);
      goIdle();

      $display("[TB] load from 1032");
      applyStimulus(1'b0, 1'b1, 32'd1032, 32'd0, lat);
      checkOutput("load_latency", 32'(lat), 32'd5);
      checkOutput("load_data", read_data, 32'hDEADBEEF);
      for (int c = 0; c <= 5; c++) checkOutput($sformatf("load_we_n_c%0d", c), obs_we[c], 32'd1);
      checkOutput("load_dq_c2", obs_dq[2], 32'h0000BEEF);
      checkOutput("load_dq_c4", obs_dq[4], 32'h0000DEAD);
      goIdle();

      $display("[TB] back-to-back store/load at 1024");
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h12345678, lat);
      checkOutput("b2b_store_latency", 32'(lat), 32'd5);
      applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0, lat);
      checkOutput("b2b_load_latency", 32'(lat), 32'd5);
      checkOutput("b2b_load_ready_c0", obs_ready[0], 32'd0);
      checkOutput("b2b_load_addr_c1", obs_addr[1], 32'd0);
      checkOutput("b2b_load_data", read_data, 32'h12345678);
      goIdle();

      $display("[TB] rd_en and wr_en together at 1028");
      applyStimulus(1'b1, 1'b1, 32'd1028, 32'h0000AAAA, lat);
      checkOutput("both_latency", 32'(lat), 32'd5);
      checkOutput("both_addr_c1", obs_addr[1], 32'd2);
      checkOutput("both_addr_c3", obs_addr[3], 32'd3);
      checkOutput("both_we_n_c1", obs_we[1], 32'd0);
      checkOutput("both_we_n_c3", obs_we[3], 32'd0);
      checkOutput("both_dq_c1", obs_dq[1], 32'h0000AAAA);
      checkOutput("both_dq_c3", obs_dq[3], 32'h00000000);
      goIdle();
      applyStimulus(1'b0, 1'b1, 32'd1028, 32'd0, lat);
      checkOutput("both_readback", read_data, 32'h0000AAAA);
      goIdle();

      $display("[TB] reset during the high half of a load");
      @(posedge clk);
      #1;
      rd_en = 1'b1;
      address = 32'd1032;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_pre_we_n", 32'(SRAM_WE_N), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      rd_en = 1'b0;
      @(negedge clk);
      checkOutput("abort_read_data", read_data, 32'd0);
      checkOutput("abort_we_n", 32'(SRAM_WE_N), 32'd1);
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_addr", 32'(SRAM_ADDR), 32'd0);
      applyStimulus(1'b0, 1'b1, 32'd1032, 32'd0, lat);
      checkOutput("after_abort_latency", 32'(lat), 32'd5);
      checkOutput("after_abort_data", read_data, 32'hDEADBEEF);
      goIdle();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bridges the pipeline MEM stage's 32-bit load/store requests to the board's 16-bit asynchronous SRAM.
- Each 32-bit access is split into two sequential 16-bit SRAM accesses: low half first, then high half.
- The SRAM bus is held for a fixed number of wait cycles per half.
- `ready` freezes the pipeline while an access is in flight. The block sits between the MEM stage and the SRAM_* pins of datapath.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles each 16-bit half occupies the bus; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- wr_en  in  1  store request; held stable by the MEM stage until ready=1.
- rd_en  in  1  load request; held stable by the MEM stage until ready=1.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load result; valid when ready=1 after a load.
- ready  out  1  combinational; 0 stalls the whole pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied to 0.
- SRAM_WE_N  out  1  active-low write strobe.

Behaviour:
- Address mapping:
  - idx = (address - BASE_ADDR) >> 2, computed in 32 bits, truncated to 17 bits. No range check; out-of-range addresses wrap.
  - Low phase: SRAM_ADDR = {idx,1'b0}. High phase: SRAM_ADDR = {idx,1'b1}.
- States: IDLE, LO, HI, DONE. Wait counter width is clog2(WAIT_CYCLES)+1.
- IDLE:
  - Request (rd_en|wr_en) seen: latch op = wr_en (write has priority if both asserted), clear counter, go to LO.
  - No request: stay in IDLE.
- LO: count WAIT_CYCLES cycles, then go to HI and clear the counter. On the last LO cycle of a read, capture SRAM_DQ into read_data[15:0].
- HI: same as LO, targeting read_data[31:16]; then go to DONE.
- DONE: unconditionally go to IDLE next cycle. The pipeline advances on the DONE edge, so a back-to-back request is first seen in IDLE the following cycle.
- ready = (IDLE && !rd_en && !wr_en) || DONE. It is 0 in the request cycle itself.
- Latency: WAIT_CYCLES=2 gives request cycle 0, LO cycles 1-2, HI cycles 3-4, ready=1 in cycle 5, for 2*WAIT_CYCLES+2 cycles total.
- Write:
  - SRAM_WE_N=0 for all cycles of LO and HI.
  - SRAM_DQ driven with write_data[15:0] in LO and write_data[31:16] in HI.
  - Address and data remain stable for the whole phase, including its first cycle.
- Read:
  - SRAM_WE_N=1 and SRAM_DQ = 16'bz.
  - read_data is held unchanged outside the capture cycles.
- Outside LO/HI writes: SRAM_WE_N=1 and SRAM_DQ = 16'bz. SRAM_ADDR holds its last value, 0 after reset.
- Reset (rst=0 at an edge, including mid-access):
  - state=IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ released.
  - An aborted write may leave the SRAM partially updated; this is acceptable.
- A request deasserted mid-access is a MEM-stage protocol violation. The controller still completes the latched op.
- A read and a write never overlap; one access is in flight at most.

Test Plan:
- Reset: hold rst=0 for 2 cycles → read_data=0, ready=1, SRAM_WE_N=1, SRAM_DQ=z, SRAM_ADDR=0.
- Store at address=1032, write_data=0xDEADBEEF, WAIT_CYCLES=2:
  - Cycles 1-2: SRAM_ADDR=4, DQ=0xBEEF, WE_N=0.
  - Cycles 3-4: SRAM_ADDR=5, DQ=0xDEAD, WE_N=0.
  - ready=1 only in cycle 5.
- Load back from 1032 with an SRAM model → read_data=0xDEADBEEF with ready=1 in cycle 5; WE_N=1 and DQ released throughout.
- Back-to-back:
  - Store 0x12345678 to 1024, then immediately load 1024 → second access begins in the cycle after DONE, and the load returns 0x12345678.
  - No cycle has ready=1 with a request pending in IDLE.
- rd_en=wr_en=1 at address 1028, write_data=0x0000AAAA → treated as a write: SRAM_ADDR 2 then 3, WE_N=0.
- Reset asserted during HI of a load → next cycle state=IDLE, read_data=0, WE_N=1. A subsequent load completes normally in 6 cycles.
